// File: rtl/pw_access_ctrl.sv
// Access sequencer in front of the password checker: keypad edge detection,
// attempt framing, timed unlock window, failure counting and lockout.
module pw_access_ctrl #(
   parameter int unsigned Bits          = 4,
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned MAX_FAILS     = 3,
   parameter int unsigned UNLOCK_CYCLES = 50,
   parameter int unsigned LOCK_CYCLES   = 200,
   parameter int unsigned KEY_TIMEOUT   = 100
) (
   input  logic                           clk,
   input  logic                           rst_a,
   input  logic                           key_valid,
   input  logic [Bits-1:0]                key_code,
   output logic                           chk_enable,
   output logic [Bits-1:0]                chk_data,
   output logic                           chk_clr_n,
   input  logic                           chk_pass,
   output logic                           unlock,
   output logic                           locked,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
   output logic                           attempt_done
);

   localparam int unsigned T_MAX0 = (KEY_TIMEOUT > UNLOCK_CYCLES) ? KEY_TIMEOUT : UNLOCK_CYCLES;
   localparam int unsigned T_MAX  = (T_MAX0 > LOCK_CYCLES) ? T_MAX0 : LOCK_CYCLES;
   localparam int unsigned TW     = $clog2(T_MAX + 1);
   localparam int unsigned DW     = $clog2(DIGITS + 1);
   localparam int unsigned FW     = $clog2(MAX_FAILS + 1);

   localparam logic [TW-1:0] KEY_LAST = TW'(KEY_TIMEOUT - 1);
   localparam logic [TW-1:0] UNL_LAST = TW'(UNLOCK_CYCLES - 1);
   localparam logic [TW-1:0] LCK_LAST = TW'(LOCK_CYCLES - 1);
   localparam logic [TW-1:0] T_SAT    = TW'(T_MAX);
   localparam logic [DW-1:0] D_FULL   = DW'(DIGITS);
   localparam logic [FW-1:0] F_MAX    = FW'(MAX_FAILS);

   typedef enum logic [2:0] {
      CLEAR, IDLE, COLLECT, CHECK1, CHECK2, UNLOCK, FAIL, LOCKOUT
   } state_t;

   state_t          state, state_n;
   logic            key_q, key_rise;
   logic [DW-1:0]   digit_cnt, digit_n;
   logic [TW-1:0]   timer, timer_n;
   logic [FW-1:0]   fail_n;
   logic            to_flag, to_n;
   logic            en_n;
   logic [Bits-1:0] data_n;

   assign key_rise = key_valid & ~key_q;

   always_comb begin
      state_n = state;
      digit_n = digit_cnt;
      timer_n = (timer == T_SAT) ? timer : timer + 1'b1;
      fail_n  = fail_count;
      to_n    = to_flag;
      en_n    = 1'b0;
      data_n  = chk_data;
      unique case (state)
         CLEAR: begin
            state_n = IDLE;
            digit_n = '0;
            timer_n = '0;
            to_n    = 1'b0;
         end
         IDLE: begin
            timer_n = '0;
            if (key_rise) begin
               en_n    = 1'b1;
               data_n  = key_code;
               digit_n = DW'(1);
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            // Digit completion first, then timeout, so a rise on the expiry cycle is dropped
            if (digit_cnt == D_FULL) begin
               state_n = CHECK1;
               timer_n = '0;
            end else if (timer == KEY_LAST) begin
               state_n = FAIL;
               to_n    = 1'b1;
            end else if (key_rise) begin
               en_n    = 1'b1;
               data_n  = key_code;
               digit_n = digit_cnt + 1'b1;
               timer_n = '0;
            end
         end
         CHECK1: state_n = CHECK2;
         CHECK2: begin
            if (chk_pass) begin
               state_n = UNLOCK;
               fail_n  = '0;
               timer_n = '0;
            end else begin
               state_n = FAIL;
            end
         end
         UNLOCK: if (timer == UNL_LAST) state_n = CLEAR;
         FAIL: begin
            fail_n = (fail_count == F_MAX) ? fail_count : fail_count + 1'b1;
            if (fail_n == F_MAX) begin
               state_n = LOCKOUT;
               timer_n = '0;
            end else begin
               state_n = CLEAR;
            end
         end
         LOCKOUT: begin
            if (timer == LCK_LAST) begin
               state_n = CLEAR;
               fail_n  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_a) begin
         state      <= CLEAR;
         key_q      <= 1'b0;
         digit_cnt  <= '0;
         timer      <= '0;
         fail_count <= '0;
         to_flag    <= 1'b0;
         chk_enable <= 1'b0;
         chk_data   <= '0;
      end else begin
         state      <= state_n;
         key_q      <= key_valid;
         digit_cnt  <= digit_n;
         timer      <= timer_n;
         fail_count <= fail_n;
         to_flag    <= to_n;
         chk_enable <= en_n;
         chk_data   <= data_n;
      end
   end

   // Clear pulse is held off while reset is asserted and fires in the first cycle after release
   assign chk_clr_n    = !((state == CLEAR) && rst_a);
   assign unlock       = (state == UNLOCK);
   assign locked       = (state == LOCKOUT);
   assign attempt_done = (state == CHECK2) || ((state == FAIL) && to_flag);

endmodule

// File: tb/tb_pw_access_ctrl.sv
// Directed/randomized bench for pw_access_ctrl with a behavioural attempt-level
// model and a stub password checker (password 6,9,8,7).
module tb_pw_access_ctrl;

   localparam int          MAX_FAILS     = 3;
   localparam int          UNLOCK_CYCLES = 50;
   localparam int          LOCK_CYCLES   = 200;
   localparam int          KEY_TIMEOUT   = 100;
   localparam logic [15:0] PASSWORD      = 16'h6987;

   logic       clk = 1'b0;
   logic       rst_a = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = '0;
   logic       chk_enable, chk_clr_n, chk_pass, unlock, locked, attempt_done;
   logic [3:0] chk_data;
   logic [1:0] fail_count;

   always #5 clk = ~clk;

   pw_access_ctrl #(
      .Bits(4), .DIGITS(4), .MAX_FAILS(3),
      .UNLOCK_CYCLES(50), .LOCK_CYCLES(200), .KEY_TIMEOUT(100)
   ) dut (
      .clk(clk), .rst_a(rst_a), .key_valid(key_valid), .key_code(key_code),
      .chk_enable(chk_enable), .chk_data(chk_data), .chk_clr_n(chk_clr_n),
      .chk_pass(chk_pass), .unlock(unlock), .locked(locked),
      .fail_count(fail_count), .attempt_done(attempt_done)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;
   int m_fails = 0;
   int last_rise = 0;

   // Event recorder and checker stub, sampled on the falling edge
   int          n_en = 0, n_clr = 0, n_unl = 0, unl_runs = 0, unl_first = 0;
   int          n_lck = 0, lck_runs = 0, n_done = 0, done_cyc = 0, n_bad = 0;
   logic [15:0] en_word = '0, stub_word = '0;
   int          stub_cnt = 0;
   logic        prev_unl = 1'b0, prev_lck = 1'b0;

   assign chk_pass = (stub_cnt == 4) && (stub_word == PASSWORD);

   always @(negedge clk) begin
      if (chk_enable) begin n_en++; en_word = {en_word[11:0], chk_data}; end
      if (!chk_clr_n) n_clr++;
      if (unlock) begin n_unl++; if (!prev_unl) begin unl_runs++; unl_first = cyc; end end
      if (locked) begin n_lck++; if (!prev_lck) lck_runs++; end
      if (attempt_done) begin n_done++; done_cyc = cyc; end
      if ((chk_enable && !chk_clr_n) || (unlock && locked)) n_bad++;
      prev_unl = unlock;
      prev_lck = locked;
      if (!rst_a || !chk_clr_n) begin stub_word = '0; stub_cnt = 0; end
      else if (chk_enable) begin stub_word = {stub_word[11:0], chk_data}; stub_cnt++; end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick(1);
   endtask

   task automatic clear_mon();
      n_en = 0; n_clr = 0; n_unl = 0; unl_runs = 0; unl_first = 0;
      n_lck = 0; lck_runs = 0; n_done = 0; done_cyc = 0; en_word = '0;
   endtask

   task automatic press(input logic [3:0] code, input int hold, input int gap);
      key_code  = code;
      key_valid = 1'b1;
      last_rise = cyc + 1;
      tick(hold);
      key_valid = 1'b0;
      key_code  = 4'($urandom);
      tick(gap);
   endtask

   task automatic reset_pulse();
      rst_a     = 1'b0;
      key_valid = 1'b0;
      tick(1);
      check("rst_unlock", 32'(unlock), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_fail_count", 32'(fail_count), 0);
      check("rst_done", 32'(attempt_done), 0);
      check("rst_enable", 32'(chk_enable), 0);
      check("rst_data", 32'(chk_data), 0);
      check("rst_clr_n", 32'(chk_clr_n), 1);
      rst_a = 1'b1;
      #1;
      check("post_rst_clr_lo", 32'(chk_clr_n), 0);
      tick(1);
      check("post_rst_clr_hi", 32'(chk_clr_n), 1);
      m_fails = 0;
   endtask

   // One full attempt; expectations come from the attempt-level rules only
   task automatic do_attempt(input logic [15:0] word);
      logic pass_exp, lock_exp;
      int   e;
      clear_mon();
      for (int i = 0; i < 4; i++)
         press(4'(word >> (12 - 4 * i)), $urandom_range(6, 1), $urandom_range(4, 1));
      e        = last_rise;
      pass_exp = (word == PASSWORD);
      if (pass_exp) m_fails = 0; else m_fails++;
      lock_exp = (m_fails == MAX_FAILS);
      if (lock_exp) begin
         for (int k = 0; k < 10; k++) press(4'($urandom), 3, 5);
         check("lock_active", 32'(locked), 1);
         check("lock_fail_count", 32'(fail_count), MAX_FAILS);
         m_fails = 0;
         wait_until(e + 4 + LOCK_CYCLES + 8);
      end else begin
         wait_until(e + 3 + (pass_exp ? UNLOCK_CYCLES : 0) + 8);
      end
      check("att_strobes", 32'(n_en), 4);
      check("att_digits", 32'(en_word), 32'(word));
      check("att_done_cnt", 32'(n_done), 1);
      check("att_done_cyc", 32'(done_cyc), 32'(e + 2));
      check("att_clr_cnt", 32'(n_clr), 1);
      check("att_fail_count", 32'(fail_count), 32'(m_fails));
      check("att_unlock_len", 32'(n_unl), pass_exp ? UNLOCK_CYCLES : 0);
      check("att_unlock_runs", 32'(unl_runs), pass_exp ? 1 : 0);
      if (pass_exp) check("att_unlock_start", 32'(unl_first), 32'(e + 3));
      check("att_lock_len", 32'(n_lck), lock_exp ? LOCK_CYCLES : 0);
      check("att_lock_runs", 32'(lck_runs), lock_exp ? 1 : 0);
   endtask

   initial begin
      int          e;
      logic [15:0] w;

      tick(1);
      reset_pulse();

      // Level-held key gives one strobe; then timeout with a rise on the expiry edge
      clear_mon();
      press(4'd6, 5, 3);
      check("hold_one_strobe", 32'(n_en), 1);
      check("hold_data", 32'(en_word), 32'h6);
      press(4'd9, $urandom_range(6, 1), $urandom_range(4, 1));
      e = last_rise;
      wait_until(e + KEY_TIMEOUT - 1);
      press(4'($urandom), 3, 4);
      wait_until(e + KEY_TIMEOUT + 8);
      m_fails = 1;
      check("to_strobes", 32'(n_en), 2);
      check("to_digits", 32'(en_word), 32'h69);
      check("to_done_cnt", 32'(n_done), 1);
      check("to_done_cyc", 32'(done_cyc), 32'(e + KEY_TIMEOUT));
      check("to_clr_cnt", 32'(n_clr), 1);
      check("to_fail_count", 32'(fail_count), 32'(m_fails));

      do_attempt(PASSWORD);
      do_attempt(16'h6981);
      for (int k = 0; k < 2; k++) begin
         w = 16'($urandom);
         if (w == PASSWORD) w = w ^ 16'h0001;
         do_attempt(w);
      end
      for (int k = 0; k < 6; k++) begin
         w = ($urandom_range(2, 0) == 0) ? PASSWORD : 16'($urandom);
         do_attempt(w);
      end
      do_attempt(PASSWORD);
      do_attempt(16'h1234);

      // Reset part-way through an attempt discards the partial digits and failures
      press(4'd6, 2, 2);
      press(4'd9, 2, 2);
      reset_pulse();
      do_attempt(PASSWORD);

      // Reset in the middle of the unlock window
      press(4'd6, 2, 1);
      press(4'd9, 2, 1);
      press(4'd8, 2, 1);
      press(4'd7, 2, 1);
      for (int k = 0; k < 20 && !unlock; k++) tick(1);
      check("mid_unlock_seen", 32'(unlock), 1);
      tick(20);
      reset_pulse();

      check("no_overlap", 32'(n_bad), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pw_access_ctrl.md
Name: pw_access_ctrl

Overview:
Access sequencer that sits in front of the password checker FSM. It converts raw, level-held keypad presses into single-cycle digit strobes, frames each attempt as DIGITS digits, and samples the checker verdict. It also drives a timed unlock window, counts failed attempts, and enforces a lockout period after MAX_FAILS failures. The checker is cleared between attempts through a dedicated active-low clear.

Parameters:
Bits, 4, key/digit code width
DIGITS, 4, digits per attempt
MAX_FAILS, 3, consecutive failures before lockout
UNLOCK_CYCLES, 50, cycles unlock is held high
LOCK_CYCLES, 200, lockout duration in cycles
KEY_TIMEOUT, 100, max cycles between accepted digits inside an attempt

Ports:
clk  in  1  system clock, rising edge
rst_a  in  1  reset, synchronous, active-low
key_valid  in  1  keypad press, level, held for any number of cycles
key_code  in  Bits  keypad code, valid while key_valid=1
chk_enable  out  1  one-cycle digit strobe to checker
chk_data  out  Bits  digit to checker, valid with chk_enable
chk_clr_n  out  1  active-low one-cycle clear to checker
chk_pass  in  1  checker verdict, level
unlock  out  1  access granted window
locked  out  1  lockout active
fail_count  out  clog2(MAX_FAILS+1)  consecutive failures
attempt_done  out  1  one-cycle pulse when an attempt resolves

Behaviour:
- Reset (rst_a=0 at a clk edge) has the following effects:
  - Outputs: unlock=0, locked=0, fail_count=0, attempt_done=0, chk_enable=0, chk_data=0, chk_clr_n=1.
  - Internal: state=CLEAR, digit/timer counters=0, key edge register=0.
  - A reset mid-attempt, mid-unlock or mid-lockout aborts it immediately.
- Edge detect runs in every state: key_rise = key_valid & ~key_q, where key_q is key_valid registered one cycle.
  - A key held across a state change produces no new rise.
  - The rise is ignored in every state other than IDLE and COLLECT.
- States:
  - CLEAR: chk_clr_n=0 for exactly this one cycle, then IDLE.
  - IDLE: on key_rise, capture key_code and go to COLLECT. In the next cycle, chk_enable=1 and chk_data=captured code; digit_cnt=1.
  - COLLECT: on each key_rise, emit the strobe the next cycle and increment digit_cnt. The inter-key timer clears on each accepted digit and increments otherwise.
    - When digit_cnt reaches DIGITS (after the strobe cycle), go to CHECK.
    - When the timer reaches KEY_TIMEOUT before DIGITS digits, go to FAIL.
  - CHECK: two cycles. chk_pass is sampled in the second cycle.
    - chk_pass=1: go to UNLOCK and set fail_count=0.
    - chk_pass=0: go to FAIL.
    - attempt_done=1 in the second CHECK cycle.
  - UNLOCK: unlock=1 for exactly UNLOCK_CYCLES cycles, then CLEAR.
  - FAIL: one cycle; fail_count increments.
    - If the new value equals MAX_FAILS, go to LOCKOUT; else go to CLEAR.
    - For the timeout path, attempt_done=1 in this cycle.
  - LOCKOUT: locked=1 for exactly LOCK_CYCLES cycles; keys ignored.
    - On exit, fail_count=0 and go to CLEAR.
- Boundaries:
  - fail_count never exceeds MAX_FAILS.
  - A key_rise in the same cycle as a timeout expiry is discarded (timeout wins).
  - chk_enable is never asserted outside IDLE/COLLECT-derived strobe cycles.
  - chk_enable and chk_clr_n=0 are never asserted in the same cycle.
- Counters are unsigned, sized clog2(max+1), and saturate at their terminal value rather than wrap.

Test Plan:
- Reset, then hold key_valid=1 for 5 cycles with key_code=6 -> exactly one chk_enable pulse with chk_data=6; chk_clr_n low for one cycle right after reset.
- Keys 6,9,8,7 (each held 5 cycles, 3-cycle gaps), checker model passes -> attempt_done pulse, unlock=1 for exactly 50 cycles, fail_count=0, then chk_clr_n pulse.
- Keys 6,9,8,1 with checker failing -> fail_count=1, unlock stays 0, return to IDLE via CLEAR.
- Three failed attempts -> locked=1 for 200 cycles, keys pressed during lockout produce no chk_enable, then fail_count=0.
- Keys 6,9 then no key for 100 cycles -> timeout, attempt_done pulse, fail_count=1, next press starts a fresh attempt (digit_cnt=1).
- Drive rst_a=0 for one cycle midway through UNLOCK -> unlock=0 on the next cycle, state CLEAR, fail_count=0.
